// File: rtl/rfq_pkg.sv
// Shared types and default sizes for the register-file write queue.
package rfq_pkg;
    localparam int RFQ_DEPTH  = 4;
    localparam int RFQ_DATA_W = 16;
    localparam int RFQ_ADDR_W = 3;

    function automatic int rfq_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int RFQ_PTR_W = rfq_ptr_w(RFQ_DEPTH);

    typedef struct packed {
        logic [RFQ_ADDR_W-1:0] rsel;
        logic [RFQ_DATA_W-1:0] data;
    } rfq_entry_t;
endpackage

// File: rtl/rfq_match.sv
// Associative lookup over the pending queue entries; the youngest match wins.
module rfq_match
    import rfq_pkg::*;
#(
    parameter int  DEPTH   = RFQ_DEPTH,
    parameter int  ADDR_W  = RFQ_ADDR_W,
    parameter int  DATA_W  = RFQ_DATA_W,
    parameter type entry_t = rfq_entry_t,
    localparam int PTR_W   = rfq_ptr_w(DEPTH)
) (
    input  entry_t            entries_i [DEPTH],
    input  logic [DEPTH-1:0]  valid_i,
    input  logic [PTR_W-1:0]  head_i,
    input  logic [ADDR_W-1:0] sel_i,
    output logic              hit_o,
    output logic [DATA_W-1:0] data_o
);
    logic [PTR_W-1:0] idx;

    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        // Walk from head (oldest) toward tail so a later match overrides an earlier one.
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_i + PTR_W'(i);
            if (valid_i[idx] && (entries_i[idx].rsel == sel_i)) begin
                hit_o  = 1'b1;
                data_o = entries_i[idx].data;
            end
        end
    end
endmodule

// File: rtl/rf_write_queue.sv
// In-order write buffer in front of the register file's single write port.
// Optional RFQ_PASSTHRU_EN: an empty, unstalled queue forwards a request straight to the port.
module rf_write_queue
    import rfq_pkg::*;
#(
    parameter int  DEPTH  = RFQ_DEPTH,
    parameter int  DATA_W = RFQ_DATA_W,
    parameter int  ADDR_W = RFQ_ADDR_W,
    localparam int PTR_W  = rfq_ptr_w(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_reg,
    input  logic [DATA_W-1:0] in_data,
    input  logic              rf_stall,
    output logic              writeEn,
    output logic [ADDR_W-1:0] writeRegSel,
    output logic [DATA_W-1:0] writeData,
    input  logic [ADDR_W-1:0] lk1Sel,
    output logic              lk1Hit,
    output logic [DATA_W-1:0] lk1Data,
    input  logic [ADDR_W-1:0] lk2Sel,
    output logic              lk2Hit,
    output logic [DATA_W-1:0] lk2Data,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              err
);
    typedef struct packed {
        logic [ADDR_W-1:0] rsel;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PTR_W:0]   head_q, head_d, tail_q, tail_d;
    logic             err_q, err_d;
    logic             full, is_empty, push, pop, passthru;
    logic [DEPTH-1:0] valid;
    logic [PTR_W-1:0] offs;

    assign count    = tail_q - head_q;
    assign is_empty = (head_q == tail_q);
    assign full     = (head_q[PTR_W] != tail_q[PTR_W]) &&
                      (head_q[PTR_W-1:0] == tail_q[PTR_W-1:0]);
    assign empty    = is_empty;
    assign in_ready = !full;
    assign err      = err_q;

`ifdef RFQ_PASSTHRU_EN
    assign passthru = is_empty & ~rf_stall & in_valid;
`else
    assign passthru = 1'b0;
`endif

    assign push = in_valid & ~full & ~passthru;
    assign pop  = ~is_empty & ~rf_stall;

    // Idle port reads all-zero so the rf bypass comparator never sees stale data.
    always_comb begin
        writeEn     = 1'b0;
        writeRegSel = '0;
        writeData   = '0;
        if (pop) begin
            writeEn     = 1'b1;
            writeRegSel = mem_q[head_q[PTR_W-1:0]].rsel;
            writeData   = mem_q[head_q[PTR_W-1:0]].data;
        end else if (passthru) begin
            writeEn     = 1'b1;
            writeRegSel = in_reg;
            writeData   = in_data;
        end
    end

    always_comb begin
        head_d = head_q + {{PTR_W{1'b0}}, pop};
        tail_d = tail_q + {{PTR_W{1'b0}}, push};
        err_d  = err_q | (in_valid & full);
    end

    always_comb begin
        valid = '0;
        offs  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs     = PTR_W'(i) - head_q[PTR_W-1:0];
            valid[i] = ({1'b0, offs} < count);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q <= '0;
            tail_q <= '0;
            err_q  <= 1'b0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            err_q  <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[tail_q[PTR_W-1:0]] <= '{rsel: in_reg, data: in_data};
    end

    rfq_match #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .entry_t(entry_t)
    ) u_match1 (
        .entries_i(mem_q), .valid_i(valid), .head_i(head_q[PTR_W-1:0]),
        .sel_i(lk1Sel), .hit_o(lk1Hit), .data_o(lk1Data)
    );

    rfq_match #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .entry_t(entry_t)
    ) u_match2 (
        .entries_i(mem_q), .valid_i(valid), .head_i(head_q[PTR_W-1:0]),
        .sel_i(lk2Sel), .hit_o(lk2Hit), .data_o(lk2Data)
    );
endmodule
